// File: rtl/pong_engine.sv
// pong_engine: per-frame game state for paddles, ball, serve sequencing, scoring and game over
module pong_engine #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_SIZE   = 64,
  parameter int PADDLE_WIDTH  = 16,
  parameter int BALL_SIZE     = 8,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_SPEED    = 2,
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_DELAY   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up1,
  input  logic       btn_dn1,
  input  logic       btn_up2,
  input  logic       btn_dn2,
  input  logic       btn_serve,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       ball_visible,
  output logic       game_over
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic signed [10:0] BS = 11'(BALL_SIZE);
  localparam logic signed [10:0] SP = 11'(BALL_SPEED);
  localparam logic signed [10:0] PS = 11'(PADDLE_SIZE);
  localparam logic signed [10:0] XR = 11'(SCREEN_WIDTH - PADDLE_WIDTH - BALL_SIZE);
  localparam logic signed [10:0] XL = 11'(PADDLE_WIDTH + BALL_SIZE);
  localparam logic signed [10:0] XM = 11'(SCREEN_WIDTH - BALL_SIZE);
  localparam logic signed [10:0] YB = 11'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [9:0] CX = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0] CY = 10'(SCREEN_HEIGHT / 2);
  localparam logic [9:0] PMAX = 10'(SCREEN_HEIGHT - PADDLE_SIZE);
  localparam logic [9:0] PINIT = 10'((SCREEN_HEIGHT - PADDLE_SIZE) / 2);
  localparam logic [9:0] STEP = 10'(PADDLE_STEP);
  localparam logic [3:0] WS = 4'(WIN_SCORE);
  state_t state, state_n;
  logic [9:0] p1_n, p2_n, bx_n, by_n;
  logic [3:0] s1_n, s2_n;
  logic vis_n, go_n, vx_neg, vy_neg, vxn_n, vyn_n, serve_left, sl_n, vy_flip, vf_n;
  logic [CW-1:0] cnt, cnt_n;
  logic signed [10:0] bx, by, p1, p2, nx, ny;
  logic top, bot, hit_r, hit_l, miss_r, miss_l, serve, over;

  function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
    return (up && !dn) ? ((y < STEP) ? '0 : y - STEP) :
           (dn && !up) ? ((y > PMAX - STEP) ? PMAX : y + STEP) : y;
  endfunction

  // Collision tests use the paddle positions from before this frame's move
  assign bx = $signed({1'b0, ball_x});
  assign by = $signed({1'b0, ball_y});
  assign p1 = $signed({1'b0, paddle1_y});
  assign p2 = $signed({1'b0, paddle2_y});
  assign nx = bx + (vx_neg ? -SP : SP);
  assign ny = by + (vy_neg ? -SP : SP);
  assign top = ny <= BS;
  assign bot = ny >= YB;
  assign hit_r = !vx_neg && bx < XR && nx >= XR && by + BS > p2 && by - BS < p2 + PS;
  assign hit_l = vx_neg && bx >= XL && nx < XL && by + BS > p1 && by - BS < p1 + PS;
  assign miss_r = !vx_neg && nx >= XM && !hit_r;
  assign miss_l = vx_neg && nx <= BS && !hit_l;

  always_comb begin
    state_n = state;
    p1_n = pad_next(paddle1_y, btn_up1, btn_dn1);
    p2_n = pad_next(paddle2_y, btn_up2, btn_dn2);
    bx_n = ball_x;
    by_n = ball_y;
    s1_n = score1;
    s2_n = score2;
    vis_n = ball_visible;
    go_n = game_over;
    vxn_n = vx_neg;
    vyn_n = vy_neg;
    sl_n = serve_left;
    vf_n = vy_flip;
    cnt_n = cnt;
    serve = 1'b0;
    over = 1'b0;
    case (state)
      IDLE: serve = btn_serve;
      SERVE: begin
        state_n = (cnt == '0) ? PLAY : SERVE;
        cnt_n = (cnt == '0) ? cnt : cnt - CW'(1);
        vxn_n = (cnt == '0) ? serve_left : vx_neg;
        vyn_n = (cnt == '0) ? vy_flip : vy_neg;
        vf_n = (cnt == '0) ? !vy_flip : vy_flip;
      end
      PLAY: begin
        if (miss_r || miss_l) begin
          s1_n = score1 + {3'b0, miss_r};
          s2_n = score2 + {3'b0, miss_l};
          sl_n = miss_l;
          over = (s1_n == WS) || (s2_n == WS);
          serve = !over;
        end else begin
          bx_n = hit_r ? 10'(XR) : hit_l ? 10'(XL) : nx[9:0];
          vxn_n = hit_r ? 1'b1 : hit_l ? 1'b0 : vx_neg;
          by_n = top ? 10'(BS) : bot ? 10'(YB) : ny[9:0];
          vyn_n = top ? 1'b0 : bot ? 1'b1 : vy_neg;
        end
      end
      OVER: begin
        serve = btn_serve;
        s1_n = btn_serve ? '0 : score1;
        s2_n = btn_serve ? '0 : score2;
        go_n = btn_serve ? 1'b0 : game_over;
      end
      default: state_n = IDLE;
    endcase
    if (serve) begin
      state_n = SERVE;
      bx_n = CX;
      by_n = CY;
      vis_n = 1'b1;
      cnt_n = CW'(SERVE_DELAY - 1);
    end
    if (over) begin
      state_n = OVER;
      bx_n = CX;
      by_n = CY;
      vis_n = 1'b0;
      go_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      paddle1_y <= PINIT;
      paddle2_y <= PINIT;
      ball_x <= CX;
      ball_y <= CY;
      score1 <= '0;
      score2 <= '0;
      ball_visible <= 1'b0;
      game_over <= 1'b0;
      vx_neg <= 1'b0;
      vy_neg <= 1'b0;
      serve_left <= 1'b0;
      vy_flip <= 1'b0;
      cnt <= '0;
    end else if (frame_tick) begin
      state <= state_n;
      paddle1_y <= p1_n;
      paddle2_y <= p2_n;
      ball_x <= bx_n;
      ball_y <= by_n;
      score1 <= s1_n;
      score2 <= s2_n;
      ball_visible <= vis_n;
      game_over <= go_n;
      vx_neg <= vxn_n;
      vy_neg <= vyn_n;
      serve_left <= sl_n;
      vy_flip <= vf_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: vector table, directed rally sequences and random play against a reference model
module tb_pong_engine;
  logic clk = 0, reset = 1, frame_tick = 0;
  logic btn_up1 = 0, btn_dn1 = 0, btn_up2 = 0, btn_dn2 = 0, btn_serve = 0;
  logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
  logic [3:0] score1, score2;
  logic ball_visible, game_over;
  int total = 0, bad = 0;
  int m_st, m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_vis, m_go, m_dir, m_sgn, m_cnt;

  typedef struct { logic u1, d1, u2, d2, t; int n, p1, p2; } pv_t;
  pv_t tbl[12];

  always #5 clk = ~clk;

  pong_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_up2(btn_up2), .btn_dn2(btn_dn2),
    .btn_serve(btn_serve),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2), .ball_visible(ball_visible), .game_over(game_over)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one state code per game phase, velocities as signed pixel counts
  task automatic model_reset();
    m_st = 0; m_p1 = 208; m_p2 = 208; m_bx = 320; m_by = 240; m_vx = 0; m_vy = 0;
    m_s1 = 0; m_s2 = 0; m_vis = 0; m_go = 0; m_dir = 1; m_sgn = 1; m_cnt = 0;
  endtask

  function automatic int mv(input int y, input logic u, input logic d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  task automatic model_serve();
    m_st = 1; m_bx = 320; m_by = 240; m_vis = 1; m_cnt = 59;
  endtask

  task automatic model_point(input int who);
    if (who == 1) begin m_s1++; m_dir = 1; end
    else begin m_s2++; m_dir = -1; end
    if (m_s1 == 9 || m_s2 == 9) begin
      m_st = 3; m_vis = 0; m_go = 1; m_bx = 320; m_by = 240;
    end else model_serve();
  endtask

  task automatic model_step();
    int o1, o2, nx, ny;
    bit hr, hl;
    o1 = m_p1; o2 = m_p2;
    m_p1 = mv(m_p1, btn_up1, btn_dn1);
    m_p2 = mv(m_p2, btn_up2, btn_dn2);
    if (m_st == 0) begin
      if (btn_serve) model_serve();
    end else if (m_st == 1) begin
      if (m_cnt == 0) begin
        m_st = 2; m_vx = 2 * m_dir; m_vy = 2 * m_sgn; m_sgn = -m_sgn;
      end else m_cnt--;
    end else if (m_st == 2) begin
      nx = m_bx + m_vx; ny = m_by + m_vy;
      hr = m_vx > 0 && m_bx + 8 < 624 && nx + 8 >= 624 && m_by + 8 > o2 && m_by - 8 < o2 + 64;
      hl = m_vx < 0 && m_bx - 8 >= 16 && nx - 8 < 16 && m_by + 8 > o1 && m_by - 8 < o1 + 64;
      if (m_vx > 0 && !hr && nx + 8 >= 640) model_point(1);
      else if (m_vx < 0 && !hl && nx - 8 <= 0) model_point(2);
      else begin
        m_bx = hr ? 616 : hl ? 24 : nx;
        if (hr) m_vx = -2;
        if (hl) m_vx = 2;
        if (ny - 8 <= 0) begin m_by = 8; m_vy = 2; end
        else if (ny + 8 >= 480) begin m_by = 472; m_vy = -2; end
        else m_by = ny;
      end
    end else if (btn_serve) begin
      m_s1 = 0; m_s2 = 0; m_go = 0; model_serve();
    end
  endtask

  task automatic chk_all();
    chk("paddle1_y", paddle1_y, m_p1);
    chk("paddle2_y", paddle2_y, m_p2);
    chk("ball_x", ball_x, m_bx);
    chk("ball_y", ball_y, m_by);
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("ball_visible", ball_visible, m_vis);
    chk("game_over", game_over, m_go);
  endtask

  task automatic cyc(input bit t, input bit r);
    frame_tick = t; reset = r;
    @(posedge clk); #1;
    if (r) model_reset(); else if (t) model_step();
    frame_tick = 0; reset = 0;
    chk_all();
  endtask

  task automatic steer();
    btn_up2 = ball_y > 240;
    btn_dn2 = !(ball_y > 240);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_p1"}, paddle1_y, 208);
    chk({tag, "_p2"}, paddle2_y, 208);
    chk({tag, "_bx"}, ball_x, 320);
    chk({tag, "_by"}, ball_y, 240);
    chk({tag, "_s1"}, score1, 0);
    chk({tag, "_s2"}, score2, 0);
    chk({tag, "_vis"}, ball_visible, 0);
    chk({tag, "_go"}, game_over, 0);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 1, 10, 168, 208};
    tbl[1]  = '{1, 0, 0, 0, 1, 41, 4, 208};
    tbl[2]  = '{1, 0, 0, 0, 1, 1, 0, 208};
    tbl[3]  = '{1, 0, 0, 0, 1, 8, 0, 208};
    tbl[4]  = '{0, 0, 0, 1, 1, 52, 0, 416};
    tbl[5]  = '{0, 0, 0, 1, 1, 5, 0, 416};
    tbl[6]  = '{0, 1, 0, 0, 1, 3, 12, 416};
    tbl[7]  = '{1, 1, 0, 0, 1, 6, 12, 416};
    tbl[8]  = '{0, 1, 1, 0, 0, 20, 12, 416};
    tbl[9]  = '{0, 1, 1, 0, 1, 1, 16, 412};
    tbl[10] = '{0, 0, 0, 1, 1, 1, 16, 416};
    tbl[11] = '{0, 0, 1, 1, 1, 4, 16, 416};
    model_reset();
    cyc(0, 1);
    cyc(1, 1);
    chk_reset_vals("reset");
    for (int i = 0; i < 12; i++) begin
      {btn_up1, btn_dn1, btn_up2, btn_dn2} = {tbl[i].u1, tbl[i].d1, tbl[i].u2, tbl[i].d2};
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].t, 0);
      chk($sformatf("tbl%0d_p1", i), paddle1_y, tbl[i].p1);
      chk($sformatf("tbl%0d_p2", i), paddle2_y, tbl[i].p2);
    end
    {btn_up1, btn_dn1, btn_up2, btn_dn2} = 4'b0;
    // Serve timing, bottom wall and right-paddle bounce
    cyc(0, 1);
    btn_serve = 1;
    cyc(1, 0);
    btn_serve = 0;
    chk("serve_vis", ball_visible, 1);
    repeat (60) cyc(1, 0);
    chk("launch_bx", ball_x, 320);
    chk("launch_by", ball_y, 240);
    cyc(0, 0);
    cyc(1, 0);
    chk("first_move_bx", ball_x, 322);
    chk("first_move_by", ball_y, 242);
    btn_dn2 = 1;
    for (int i = 0; i < 300 && ball_y != 472; i++) cyc(1, 0);
    chk("bottom_by", ball_y, 472);
    chk("bottom_bx", ball_x, 552);
    cyc(1, 0);
    chk("bottom_next_by", ball_y, 470);
    for (int i = 0; i < 200 && ball_x != 616; i++) cyc(1, 0);
    chk("rbounce_bx", ball_x, 616);
    chk("rbounce_by", ball_y, 408);
    chk("rbounce_s1", score1, 0);
    cyc(1, 0);
    chk("rbounce_next_bx", ball_x, 614);
    chk("rbounce_next_by", ball_y, 406);
    // Miss on the right with paddle2 parked at the top
    cyc(0, 1);
    btn_dn2 = 0; btn_up2 = 1; btn_serve = 1;
    cyc(1, 0);
    btn_serve = 0;
    for (int i = 0; i < 400 && score1 == 0; i++) cyc(1, 0);
    chk("miss_s1", score1, 1);
    chk("miss_bx", ball_x, 320);
    chk("miss_by", ball_y, 240);
    chk("miss_vis", ball_visible, 1);
    repeat (61) cyc(1, 0);
    chk("relaunch_bx", ball_x, 322);
    chk("relaunch_by", ball_y, 238);
    // Keep paddle2 away from the ball so player 1 scores each rally
    for (int i = 0; i < 5000 && score1 < 3; i++) begin steer(); cyc(1, 0); end
    chk("run_s1_3", score1, 3);
    repeat (70) begin steer(); cyc(1, 0); end
    cyc(1, 1);
    chk_reset_vals("midplay_reset");
    cyc(1, 0);
    chk("idle_vis", ball_visible, 0);
    btn_serve = 1;
    cyc(1, 0);
    btn_serve = 0;
    for (int i = 0; i < 10000 && score1 < 8; i++) begin steer(); cyc(1, 0); end
    chk("run_s1_8", score1, 8);
    btn_serve = 1;
    for (int i = 0; i < 1000 && !game_over; i++) begin steer(); cyc(1, 0); end
    chk("over_s1", score1, 9);
    chk("over_s2", score2, 0);
    chk("over_go", game_over, 1);
    chk("over_vis", ball_visible, 0);
    chk("over_bx", ball_x, 320);
    cyc(1, 0);
    btn_serve = 0;
    chk("restart_s1", score1, 0);
    chk("restart_go", game_over, 0);
    chk("restart_vis", ball_visible, 1);
    {btn_up1, btn_dn1, btn_up2, btn_dn2} = 4'b0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_up1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) btn_dn1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) btn_up2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) btn_dn2 = 1'($urandom_range(0, 1));
      btn_serve = ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1999) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
